// File: rtl/exec_mem_core.sv
// Decode, ALU and 256-byte data memory for the 8-bit single-cycle CPU.
// Everything except the memory contents is combinational from the inputs.
module exec_mem_core #(
  parameter int DM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [15:0] inst,
  input  logic [7:0] r_data_0,
  input  logic [7:0] r_data_1,
  input  logic [7:0] pc_plus1,
  output logic [2:0] rf_addr_0,
  output logic [2:0] rf_addr_1,
  output logic [2:0] rf_w_addr,
  output logic       rf_w_en,
  output logic [7:0] rf_w_data,
  output logic [7:0] imm,
  output logic       branch_taken,
  output logic [7:0] alu_out,
  output logic [7:0] dm_rdata
);

  typedef enum logic [3:0] {
    OP_R    = 4'h0,
    OP_ADDI = 4'h1,
    OP_LI   = 4'h2,
    OP_LW   = 4'h3,
    OP_SW   = 4'h4,
    OP_BEQ  = 4'h5,
    OP_BNE  = 4'h6,
    OP_BLT  = 4'h7,
    OP_JAL  = 4'h8
  } opcode_e;

  logic [3:0] op;
  logic [2:0] ra, rb, rc, fn;
  logic       is_load, is_jal, is_sw;
  logic [7:0] op_b;
  logic [7:0] dm_q [DM_DEPTH];
  logic [7:0] dm_d [DM_DEPTH];

  assign op = inst[15:12];
  assign ra = inst[11:9];
  assign rb = inst[8:6];
  assign rc = inst[5:3];
  assign fn = inst[2:0];

  // Instruction decode: register addresses, immediate, write enable, branch decision.
  always_comb begin
    rf_addr_0    = ra;
    rf_addr_1    = rb;
    rf_w_addr    = ra;
    rf_w_en      = 1'b0;
    imm          = 8'h00;
    branch_taken = 1'b0;
    is_load      = 1'b0;
    is_jal       = 1'b0;
    is_sw        = 1'b0;
    case (op)
      OP_R: begin
        rf_addr_0 = rb;
        rf_addr_1 = rc;
        rf_w_en   = 1'b1;
      end
      OP_ADDI, OP_LI: begin
        imm     = inst[7:0];
        rf_w_en = 1'b1;
      end
      OP_LW: begin
        imm     = inst[7:0];
        rf_w_en = 1'b1;
        is_load = 1'b1;
      end
      OP_SW: begin
        imm       = inst[7:0];
        rf_addr_1 = ra;
        is_sw     = 1'b1;
      end
      OP_BEQ: begin
        imm          = {{2{inst[5]}}, inst[5:0]};
        branch_taken = (r_data_0 == r_data_1);
      end
      OP_BNE: begin
        imm          = {{2{inst[5]}}, inst[5:0]};
        branch_taken = (r_data_0 != r_data_1);
      end
      OP_BLT: begin
        imm          = {{2{inst[5]}}, inst[5:0]};
        branch_taken = ($signed(r_data_0) < $signed(r_data_1));
      end
      OP_JAL: begin
        imm          = inst[7:0];
        rf_w_en      = 1'b1;
        branch_taken = 1'b1;
        is_jal       = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU: R-type follows fn, LI passes operand 1, everything else adds.
  always_comb begin
    op_b    = ((op == OP_ADDI) || (op == OP_LI)) ? imm : r_data_1;
    alu_out = r_data_0 + op_b;
    if (op == OP_LI) begin
      alu_out = op_b;
    end else if (op == OP_R) begin
      case (fn)
        3'd0:    alu_out = r_data_0 + op_b;
        3'd1:    alu_out = r_data_0 - op_b;
        3'd2:    alu_out = r_data_0 & op_b;
        3'd3:    alu_out = r_data_0 | op_b;
        3'd4:    alu_out = r_data_0 ^ op_b;
        3'd5:    alu_out = r_data_0 << op_b[2:0];
        3'd6:    alu_out = r_data_0 >> op_b[2:0];
        default: alu_out = {7'd0, ($signed(r_data_0) < $signed(op_b))};
      endcase
    end
  end

  // Load data and write-back selection (load wins over link, link over ALU).
  always_comb begin
    dm_rdata = is_load ? dm_q[inst[7:0]] : 8'h00;
    if (is_load) begin
      rf_w_data = dm_rdata;
    end else if (is_jal) begin
      rf_w_data = pc_plus1;
    end else begin
      rf_w_data = alu_out;
    end
  end

  // Next memory image: the stored byte replaces the addressed entry on SW.
  always_comb begin
    dm_d = dm_q;
    if (is_sw) begin
      dm_d[inst[7:0]] = r_data_1;
    end
  end

  // Memory register; reset clears every byte and drops any concurrent store.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dm_q <= '{default: 8'h00};
    end else begin
      dm_q <= dm_d;
    end
  end

endmodule

// File: tb/tb_exec_mem_core.sv
// Randomized bench for exec_mem_core with an arithmetic reference model.
module tb_exec_mem_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] inst = 16'h0000;
  logic [7:0]  r_data_0 = 8'h00, r_data_1 = 8'h00, pc_plus1 = 8'h00;
  logic [2:0]  rf_addr_0, rf_addr_1, rf_w_addr;
  logic        rf_w_en, branch_taken;
  logic [7:0]  rf_w_data, imm, alu_out, dm_rdata;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;
  int mem [256];

  exec_mem_core #(.DM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .inst(inst),
    .r_data_0(r_data_0), .r_data_1(r_data_1), .pc_plus1(pc_plus1),
    .rf_addr_0(rf_addr_0), .rf_addr_1(rf_addr_1), .rf_w_addr(rf_w_addr),
    .rf_w_en(rf_w_en), .rf_w_data(rf_w_data), .imm(imm),
    .branch_taken(branch_taken), .alu_out(alu_out), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (inst=0x%04h t=%0t)", name, act, exp, inst, $time);
  endtask

  function automatic int sgn8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference semantics of one instruction, in plain integer arithmetic.
  task automatic model(input int op, input int ra, input int rb, input int rc, input int fn,
                       input int low8, input int low6, input int a, input int b, input int pc,
                       output int e_a0, output int e_a1, output int e_we, output int e_wd,
                       output int e_imm, output int e_br, output int e_alu, output int e_alu_ok,
                       output int e_dm);
    int res;
    e_a0 = ra; e_a1 = rb; e_we = 0; e_wd = 0; e_imm = 0; e_br = 0;
    e_alu = 0; e_alu_ok = 0; e_dm = 0;
    if (op == 0) begin
      e_a0 = rb; e_a1 = rc;
      case (fn)
        0: res = (a + b) % 256;
        1: res = (a - b + 256) % 256;
        2: res = a & b;
        3: res = a | b;
        4: res = a ^ b;
        5: res = (a * (1 << (b % 8))) % 256;
        6: res = a / (1 << (b % 8));
        default: res = (sgn8(a) < sgn8(b)) ? 1 : 0;
      endcase
      e_alu = res; e_alu_ok = 1; e_we = 1; e_wd = res;
    end else if (op == 1) begin
      e_imm = low8; e_alu = (a + low8) % 256; e_alu_ok = 1; e_we = 1; e_wd = e_alu;
    end else if (op == 2) begin
      e_imm = low8; e_alu = low8; e_alu_ok = 1; e_we = 1; e_wd = low8;
    end else if (op == 3) begin
      e_imm = low8; e_dm = mem[low8]; e_we = 1; e_wd = e_dm;
    end else if (op == 4) begin
      e_imm = low8; e_a1 = ra;
    end else if (op >= 5 && op <= 7) begin
      e_imm = (low6 >= 32) ? low6 + 192 : low6;
      if (op == 5) e_br = (a == b) ? 1 : 0;
      if (op == 6) e_br = (a != b) ? 1 : 0;
      if (op == 7) e_br = (sgn8(a) < sgn8(b)) ? 1 : 0;
    end else if (op == 8) begin
      e_imm = low8; e_br = 1; e_we = 1; e_wd = pc;
    end
  endtask

  // Reference memory: follows reset and stores on each rising edge.
  always @(posedge clk) begin
    if (!rst) begin
      foreach (mem[k]) mem[k] = 0;
      chk_en = 1'b1;
    end else if (inst[15:12] == 4'h4) begin
      mem[inst[7:0]] = r_data_1;
    end
  end

  // Compare process: every falling edge once memory is defined.
  always @(negedge clk) begin
    int e_a0, e_a1, e_we, e_wd, e_imm, e_br, e_alu, e_alu_ok, e_dm;
    if (chk_en) begin
      model(inst[15:12], inst[11:9], inst[8:6], inst[5:3], inst[2:0], inst[7:0], inst[5:0],
            r_data_0, r_data_1, pc_plus1,
            e_a0, e_a1, e_we, e_wd, e_imm, e_br, e_alu, e_alu_ok, e_dm);
      chk("rf_addr_0", rf_addr_0, e_a0);
      chk("rf_addr_1", rf_addr_1, e_a1);
      chk("rf_w_en", rf_w_en, e_we);
      if (e_we != 0) begin
        chk("rf_w_addr", rf_w_addr, inst[11:9]);
        chk("rf_w_data", rf_w_data, e_wd);
      end
      chk("imm", imm, e_imm);
      chk("branch_taken", branch_taken, e_br);
      if (e_alu_ok != 0) chk("alu_out", alu_out, e_alu);
      chk("dm_rdata", dm_rdata, e_dm);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] i, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] pc);
    inst = i; r_data_0 = a; r_data_1 = b; pc_plus1 = pc;
    #2;
  endtask

  initial begin
    // Reset one edge with an LW on the bus, then read back a cleared byte.
    rst = 1'b0;
    drive(16'h347F, 8'h00, 8'h00, 8'h00);
    tick();
    rst = 1'b1;
    drive(16'h347F, 8'h00, 8'h00, 8'h00);
    chk("lit_lw_reset_dm", dm_rdata, 8'h00);
    chk("lit_lw_reset_we", rf_w_en, 1);
    chk("lit_lw_reset_wd", rf_w_data, 8'h00);
    tick();

    drive(16'h0298, 8'hF0, 8'h20, 8'h00);
    chk("lit_add", alu_out, 8'h10);
    chk("lit_r_addr0", rf_addr_0, 2);
    chk("lit_r_addr1", rf_addr_1, 3);
    tick();
    drive(16'h0299, 8'hF0, 8'h20, 8'h00);
    chk("lit_sub", alu_out, 8'hD0);
    tick();
    drive(16'h029F, 8'hF0, 8'h20, 8'h00);
    chk("lit_slt", alu_out, 8'h01);
    tick();

    drive(16'h4A12, 8'h00, 8'hA5, 8'h00);
    chk("lit_sw_addr1", rf_addr_1, 5);
    chk("lit_sw_we", rf_w_en, 0);
    tick();
    drive(16'h3A12, 8'h00, 8'h00, 8'h00);
    chk("lit_lw_data", rf_w_data, 8'hA5);
    chk("lit_lw_waddr", rf_w_addr, 5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(16'h3A12, 8'h00, 8'h00, 8'h00);
    chk("lit_lw_after_rst", rf_w_data, 8'h00);
    tick();

    drive(16'h52BE, 8'h33, 8'h33, 8'h00);
    chk("lit_beq_taken", branch_taken, 1);
    chk("lit_beq_imm", imm, 8'hFE);
    chk("lit_beq_we", rf_w_en, 0);
    tick();
    drive(16'h52BE, 8'h33, 8'h34, 8'h00);
    chk("lit_beq_not", branch_taken, 0);
    chk("lit_beq_we2", rf_w_en, 0);
    tick();

    drive(16'h8605, 8'h00, 8'h00, 8'h11);
    chk("lit_jal_br", branch_taken, 1);
    chk("lit_jal_waddr", rf_w_addr, 3);
    chk("lit_jal_wdata", rf_w_data, 8'h11);
    chk("lit_jal_imm", imm, 8'h05);
    tick();

    drive(16'hFA12, 8'h00, 8'h5A, 8'h00);
    chk("lit_nop_we", rf_w_en, 0);
    chk("lit_nop_br", branch_taken, 0);
    tick();
    drive(16'h3A12, 8'h00, 8'h00, 8'h00);
    chk("lit_nop_no_store", dm_rdata, 8'h00);
    tick();

    // Random traffic; addresses often confined to 16 bytes so loads hit stores.
    for (int n = 0; n < 800; n++) begin
      logic [15:0] ri;
      logic [7:0]  ra0, rb1;
      ri = 16'($urandom);
      if ($urandom_range(0, 2) != 0) ri[7:4] = 4'h0;
      if ($urandom_range(0, 3) == 0) ri[15:12] = 4'($urandom_range(3, 4));
      ra0 = 8'($urandom);
      rb1 = ($urandom_range(0, 3) == 0) ? ra0 : 8'($urandom);
      rst = ($urandom_range(0, 59) != 0);
      drive(ri, ra0, rb1, 8'($urandom));
      tick();
    end
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exec_mem_core.md
Name: exec_mem_core

Overview:
- Combined instruction-decode, ALU and data-memory stage of the 8-bit single-cycle CPU. The PC, instruction memory and register file stay outside this block.
- Takes a 16-bit instruction and the two register-file read values.
- Produces:
  - register-file read addresses
  - write-back address, enable and data
  - branch decision and target offset
  - data-memory load data
- Data memory is 256 x 8, with synchronous write and combinational read.

Parameters:
- DM_DEPTH, 256, number of data-memory bytes. Address is the 8-bit immediate.

Ports:
- clk  input  1  Single clock. All state updates on rising edge.
- rst  input  1  Synchronous, active-low reset.
- inst  input  16  Current instruction.
- r_data_0  input  8  Register-file value at rf_addr_0.
- r_data_1  input  8  Register-file value at rf_addr_1.
- pc_plus1  input  8  PC+1, used for JAL link.
- rf_addr_0  output  3  Register-file read address 0.
- rf_addr_1  output  3  Register-file read address 1.
- rf_w_addr  output  3  Write-back register.
- rf_w_en  output  1  Write-back enable.
- rf_w_data  output  8  Write-back data.
- imm  output  8  Decoded immediate or branch offset.
- branch_taken  output  1  PC must load PC+imm (mod 256).
- alu_out  output  8  ALU result.
- dm_rdata  output  8  Data-memory read data (0 when not a load).

Behaviour:
- Fields:
  - op=inst[15:12], ra=inst[11:9], rb=inst[8:6], rc=inst[5:3], fn=inst[2:0].
  - Default rf_addr_0=ra, rf_addr_1=rb.
- op 0000, R-type: rd=ra; operands R[rb] op R[rc] (rf_addr_0=rb, rf_addr_1=rc). fn selects:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL by r1[2:0]
  - 110 SRL by r1[2:0], logical
  - 111 SLT, signed, result 1/0
- op 0001 ADDI: R[ra]=R[ra]+inst[7:0]; rf_addr_0=ra.
- op 0010 LI: R[ra]=inst[7:0]; ALU passes operand 1.
- op 0011 LW: R[ra]=DM[inst[7:0]].
- op 0100 SW: DM[inst[7:0]]=R[ra]; rf_addr_1=ra; no register write.
- op 0101 BEQ / 0110 BNE / 0111 BLT (signed):
  - Compare R[ra] against R[rb].
  - imm = sign-extend(inst[5:0]).
  - branch_taken when the condition holds.
  - No register write.
- op 1000 JAL: R[ra]=pc_plus1; imm=inst[7:0] (two's complement); branch_taken=1.
- All other opcodes (1001–1111) are NOP: rf_w_en=0, DM write disabled, branch_taken=0, imm=0.
- imm for R-type is 0.
- Operand 1 mux: imm for ADDI/LI, else r_data_1.
- Arithmetic is 8-bit, wraps mod 256; no flags.
- Write-back mux priority: load → dm_rdata; JAL → pc_plus1; else alu_out.
- All outputs except DM contents are purely combinational from inst, r_data_0, r_data_1, pc_plus1.
- DM write occurs at the rising edge when op=SW and rst=1.
- DM read is combinational; read-during-write returns the old byte until the edge.
- Reset: on a rising edge with rst=0, all 256 DM bytes clear to 0 and any SW in that cycle is ignored. Decode outputs are unaffected by rst.

Test Plan:
- Hold rst=0 for 1 edge, release; LW addr 0x7F -> dm_rdata=0x00, rf_w_en=1, rf_w_data=0x00.
- R-type ADD with r_data_0=0xF0, r_data_1=0x20 -> alu_out=0x10.
  - Same operands, SUB -> 0xD0.
  - Same operands, SLT -> 1.
  - Check rf_addr_0=rb, rf_addr_1=rc.
- SW addr 0x12 with r_data_1=0xA5, one edge, then LW 0x12 -> rf_w_data=0xA5, rf_w_addr=ra.
  - Then reset and re-LW -> 0x00.
- BEQ, offset inst[5:0]=0x3E:
  - Equal operands 0x33/0x33 -> branch_taken=1, imm=0xFE.
  - Operands 0x33/0x34 -> branch_taken=0.
  - rf_w_en=0 in both cases.
- JAL ra=3, imm 0x05, pc_plus1=0x11 -> branch_taken=1, rf_w_addr=3, rf_w_data=0x11, imm=0x05.
- Opcode 1111 with SW-like fields, clock edge -> DM unchanged, rf_w_en=0, branch_taken=0.
